// File: rtl/fsm_cnt_dw.sv
// Run/done controller: a start pulse latches a cycle count, the block counts it
// out in RUN (with hold and abort), then emits a single-cycle done pulse.
module fsm_cnt_dw #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_run,
    input  logic [CNT_WIDTH-1:0] i_num_cnt,
    input  logic                 i_hold,
    input  logic                 i_abort,
    output logic                 o_idle,
    output logic                 o_running,
    output logic                 o_done,
    output logic                 o_err,
    output logic [CNT_WIDTH-1:0] o_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t               c_state;
    state_t               n_state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] num;
    logic                 start_ok;
    logic                 start_zero;
    logic                 terminal;

    assign start_ok   = i_run && (i_num_cnt != '0);
    assign start_zero = i_run && (i_num_cnt == '0);
    assign terminal   = (cnt == (num - CNT_WIDTH'(1)));

    always_comb begin
        n_state = c_state;
        case (c_state)
            S_IDLE: begin
                if (start_ok) begin
                    n_state = S_RUN;
                end
            end
            S_RUN: begin
                // abort beats hold, and hold beats terminal count
                if (i_abort) begin
                    n_state = S_IDLE;
                end else if (i_hold) begin
                    n_state = S_RUN;
                end else if (terminal) begin
                    n_state = S_DONE;
                end
            end
            S_DONE: begin
                n_state = S_IDLE;
            end
            default: begin
                n_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c_state <= S_IDLE;
            cnt     <= '0;
            num     <= '0;
            o_err   <= 1'b0;
        end else begin
            c_state <= n_state;
            o_err   <= (c_state == S_IDLE) && start_zero;
            case (c_state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start_ok) begin
                        num <= i_num_cnt;
                    end
                end
                S_RUN: begin
                    if (i_abort) begin
                        cnt <= '0;
                    end else if (i_hold) begin
                        cnt <= cnt;
                    end else if (terminal) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    assign o_idle    = (c_state == S_IDLE);
    assign o_running = (c_state == S_RUN);
    assign o_done    = (c_state == S_DONE);
    assign o_cnt     = (c_state == S_RUN) ? cnt : '0;

endmodule

// File: tb/tb_fsm_cnt_dw.sv
// Bench for fsm_cnt_dw: an 8-bit and a 4-bit instance driven side by side,
// checked every cycle against a transaction-level reference model.
module tb_fsm_cnt_dw;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       hold = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] num8 = '0;
    logic [3:0] num4 = '0;

    logic       idle8, running8, done8, err8;
    logic [7:0] cnt8;
    logic       idle4, running4, done4, err4;
    logic [3:0] cnt4;

    int n_cmp = 0;
    int n_fail = 0;
    int max8 = 0;
    int max4 = 0;
    int dones4 = 0;
    int dones8 = 0;

    always #5 clk = ~clk;

    fsm_cnt_dw #(.CNT_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .i_run(run), .i_num_cnt(num8),
        .i_hold(hold), .i_abort(abort),
        .o_idle(idle8), .o_running(running8), .o_done(done8),
        .o_err(err8), .o_cnt(cnt8)
    );

    fsm_cnt_dw #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .i_run(run), .i_num_cnt(num4),
        .i_hold(hold), .i_abort(abort),
        .o_idle(idle4), .o_running(running4), .o_done(done4),
        .o_err(err4), .o_cnt(cnt4)
    );

    // A run is described by how many counted cycles have elapsed out of n,
    // plus a pending done cycle and a pending error cycle.
    typedef struct {
        bit active;
        bit done_p;
        bit err;
        int elapsed;
        int n;
    } mdl_t;

    mdl_t m8, m4;

    function automatic mdl_t mstep(mdl_t m, bit rst, bit r, bit h, bit a, int req);
        mdl_t x = m;
        x.err = 1'b0;
        if (rst) begin
            x.active = 0; x.done_p = 0; x.elapsed = 0; x.n = 0;
        end else if (m.done_p) begin
            x.done_p = 0;
        end else if (m.active) begin
            if (a) begin
                x.active = 0; x.elapsed = 0;
            end else if (!h) begin
                if (m.elapsed + 1 == m.n) begin
                    x.active = 0; x.done_p = 1; x.elapsed = 0;
                end else begin
                    x.elapsed = m.elapsed + 1;
                end
            end
        end else if (r) begin
            if (req == 0) x.err = 1'b1;
            else begin
                x.active = 1; x.elapsed = 0; x.n = req;
            end
        end
        return x;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("idle8", int'(idle8), int'(!(m8.active || m8.done_p)));
        chk("running8", int'(running8), int'(m8.active));
        chk("done8", int'(done8), int'(m8.done_p));
        chk("err8", int'(err8), int'(m8.err));
        chk("cnt8", int'(cnt8), m8.active ? m8.elapsed : 0);
        chk("idle4", int'(idle4), int'(!(m4.active || m4.done_p)));
        chk("running4", int'(running4), int'(m4.active));
        chk("done4", int'(done4), int'(m4.done_p));
        chk("err4", int'(err4), int'(m4.err));
        chk("cnt4", int'(cnt4), m4.active ? m4.elapsed : 0);
    endtask

    // Advance one clock: the model sees the same inputs the DUTs sample.
    task automatic tick();
        m8 = mstep(m8, reset, run, hold, abort, int'(num8));
        m4 = mstep(m4, reset, run, hold, abort, int'(num4));
        @(posedge clk);
        #1;
        check_all();
        if (int'(cnt8) > max8) max8 = int'(cnt8);
        if (int'(cnt4) > max4) max4 = int'(cnt4);
        if (done8) dones8++;
        if (done4) dones4++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        m8 = '{0, 0, 0, 0, 0};
        m4 = '{0, 0, 0, 0, 0};

        // reset state
        reset = 1'b1;
        ticks(2);
        chk("rst_idle", int'(idle8), 1);
        chk("rst_cnt", int'(cnt8), 0);
        reset = 1'b0;
        tick();

        // basic run N=5
        run = 1'b1; num8 = 8'd5; num4 = 4'd5;
        tick();
        run = 1'b0;
        ticks(7);

        // hold in RUN at o_cnt=1, then hold during IDLE
        run = 1'b1; num8 = 8'd3; num4 = 4'd3;
        tick();
        run = 1'b0;
        tick();
        hold = 1'b1;
        ticks(2);
        chk("hold_cnt", int'(cnt8), 1);
        hold = 1'b0;
        ticks(5);
        hold = 1'b1;
        ticks(3);
        hold = 1'b0;

        // abort at o_cnt=4, num changes after start have no effect
        run = 1'b1; num8 = 8'd10; num4 = 4'd10;
        tick();
        run = 1'b0; num8 = 8'd2; num4 = 4'd2;
        ticks(4);
        chk("pre_abort_cnt", int'(cnt8), 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", int'(idle8), 1);
        ticks(3);

        // abort together with hold
        run = 1'b1; num8 = 8'd6; num4 = 4'd6;
        tick();
        run = 1'b0;
        ticks(2);
        abort = 1'b1; hold = 1'b1;
        tick();
        abort = 1'b0; hold = 1'b0;
        ticks(2);

        // zero count error, then continuous run with N=2
        run = 1'b1; num8 = 8'd0; num4 = 4'd0;
        tick();
        chk("err_pulse", int'(err8), 1);
        run = 1'b0;
        ticks(2);
        run = 1'b1; num8 = 8'd2; num4 = 4'd2;
        dones8 = 0;
        ticks(12);
        chk("b2b_dones", dones8, 3);
        run = 1'b0;
        ticks(4);

        // reset mid-run at o_cnt=3
        run = 1'b1; num8 = 8'd8; num4 = 4'd8;
        tick();
        run = 1'b0;
        ticks(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_cnt", int'(cnt8), 0);
        ticks(3);

        // maximum counts: 15 for the 4-bit instance, 255 for the 8-bit one
        max4 = 0; max8 = 0; dones4 = 0; dones8 = 0;
        run = 1'b1; num8 = 8'd255; num4 = 4'd15;
        tick();
        run = 1'b0;
        ticks(260);
        chk("max4", max4, 14);
        chk("max8", max8, 254);
        chk("dones4", dones4, 1);
        chk("dones8", dones8, 1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            run   = ($urandom_range(0, 9) < 3);
            hold  = ($urandom_range(0, 9) < 2);
            abort = ($urandom_range(0, 39) == 0);
            num8  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            num4  = 4'($urandom);
            tick();
        end
        reset = 1'b0; run = 1'b0; hold = 1'b0; abort = 1'b0;
        ticks(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_cnt_dw.md
Name: fsm_cnt_dw

Overview:
- Parametrised run/done controller, successor of the basic IDLE/RUN/DONE handshake FSM.
- A start pulse latches a programmable cycle count. The block then counts in RUN, with hold and abort support. At terminal count it issues a single-cycle done pulse.
- Sits between a top-level sequencer and a datapath that needs a fixed-length active window.

Parameters:
- CNT_WIDTH, 8, width of the count request, internal counter and o_cnt; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
- i_run  input  1  start request; honoured only in S_IDLE.
- i_num_cnt  input  CNT_WIDTH  number of RUN cycles to execute; sampled with i_run.
- i_hold  input  1  pauses counting while in S_RUN.
- i_abort  input  1  cancels an active run.
- o_idle  output  1  high while in S_IDLE.
- o_running  output  1  high while in S_RUN.
- o_done  output  1  one-cycle pulse in S_DONE after successful completion.
- o_err  output  1  one-cycle pulse when i_run is sampled in S_IDLE with i_num_cnt == 0.
- o_cnt  output  CNT_WIDTH  current counter value; 0 outside S_RUN.

Behaviour:
- States: S_IDLE=2'b00, S_RUN=2'b01, S_DONE=2'b10. Encoding 2'b11 is illegal and returns to S_IDLE on the next edge.
- Structure: registered c_state; combinational n_state; all outputs decoded from registered state/counter, except o_err, which is a register.
- Reset (reset=1 at a rising edge): c_state=S_IDLE, counter=0, latched count=0, o_err=0. Resulting outputs: o_idle=1, o_running=0, o_done=0, o_cnt=0. Reset overrides every other input in any state, including mid-run.
- S_IDLE:
  - i_run=1 and i_num_cnt!=0: latch i_num_cnt as N, counter=0, next S_RUN.
  - i_run=1 and i_num_cnt==0: stay in S_IDLE; o_err=1 for exactly the next cycle.
  - i_hold and i_abort are ignored in S_IDLE.
- S_RUN, evaluated in priority order each edge:
  1. i_abort=1: next S_IDLE, counter cleared. No o_done, no o_err.
  2. i_hold=1: state and counter frozen.
  3. counter==N-1: next S_DONE, counter cleared.
  4. Otherwise: counter+1.
- S_DONE: o_done=1 for this single cycle; next S_IDLE unconditionally. i_run, i_abort and i_hold are ignored in S_DONE.
- i_run while in S_RUN or S_DONE is ignored and not queued. A new run needs i_run to be high on a cycle where c_state==S_IDLE.
- i_num_cnt changes after the start cycle have no effect on the active run.
- Latency with no hold: i_run sampled at edge T → S_RUN for edges T+1..T+N (o_cnt 0..N-1) → o_done high in cycle after edge T+N → S_IDLE after edge T+N+1. Each held cycle adds one cycle.
- Wrap-around: the counter never wraps. Maximum N = 2^CNT_WIDTH-1, so o_cnt maximum = 2^CNT_WIDTH-2. N=1 yields exactly one S_RUN cycle.
- Simultaneous events: in S_RUN, abort wins over hold and over terminal count. With hold and terminal count together, the block holds.
- Back-to-back runs: earliest restart is i_run sampled on the first S_IDLE cycle after S_DONE, giving a minimum period of N+2 cycles.

Test Plan:
- Reset, then i_run=1 with i_num_cnt=5 for one cycle → o_running high 5 cycles with o_cnt 0,1,2,3,4 → o_done one cycle → o_idle=1.
- i_num_cnt=3, i_hold=1 for 2 cycles while o_cnt=1 → o_cnt stays 1 for 3 cycles total; o_done 6 cycles after start; hold during S_IDLE has no effect.
- i_num_cnt=10, i_abort=1 when o_cnt=4 → o_idle=1 next cycle, o_cnt=0, o_done never asserts. Abort+hold asserted together → abort wins.
- i_run with i_num_cnt=0 → o_err single pulse, stays S_IDLE. i_run held high continuously with N=2 → runs repeat every 4 cycles.
- reset=1 mid-run at o_cnt=3 (N=8) → next cycle o_idle=1, o_cnt=0, o_done=0. CNT_WIDTH=4, N=15 → o_cnt reaches 14, then o_done.
